// File: rtl/wb_queue.sv
// Writeback queue: buffers multi-cycle producer results and sequences them onto
// the register file's single write port, with the ALU taking priority.
module wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [AW-1:0]              in_rd,
  input  logic [DW-1:0]              in_data,
  input  logic                       alu_wr,
  input  logic [AW-1:0]              alu_rd,
  input  logic [DW-1:0]              alu_data,
  output logic                       wb_en,
  output logic [AW-1:0]              wb_rd,
  output logic [DW-1:0]              wb_data,
  input  logic [AW-1:0]              q_rs,
  input  logic [AW-1:0]              q_rs2,
  output logic                       hit_a,
  output logic                       hit_b,
  output logic                       waw_hit,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  // Handshake: a producer result transfers on the rising edge where
  // in_valid && in_ready; while in_ready is low the producer holds in_rd/in_data.
  logic [AW-1:0]    ent_rd    [DEPTH];
  logic [DW-1:0]    ent_data  [DEPTH];
  logic [DEPTH-1:0] ent_valid;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  // The ALU owns the port whenever it asks; the queue only drains on free cycles.
  assign pop      = !alu_wr && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ent_valid <= '0;
    end else begin
      if (pop) begin
        ent_valid[rd_ptr] <= 1'b0;
        rd_ptr            <= rd_ptr + 1'b1;
      end
      if (push) begin
        ent_rd[wr_ptr]    <= in_rd;
        ent_data[wr_ptr]  <= in_data;
        ent_valid[wr_ptr] <= 1'b1;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_en   <= 1'b0;
      wb_rd   <= '0;
      wb_data <= '0;
    end else if (alu_wr) begin
      wb_en   <= 1'b1;
      wb_rd   <= alu_rd;
      wb_data <= alu_data;
    end else if (!empty) begin
      wb_en   <= 1'b1;
      wb_rd   <= ent_rd[rd_ptr];
      wb_data <= ent_data[rd_ptr];
    end else begin
      wb_en   <= 1'b0;
    end
  end

  // The write stage still counts as pending: the register file captures it next edge.
  always_comb begin
    hit_a   = wb_en && (wb_rd == q_rs);
    hit_b   = wb_en && (wb_rd == q_rs2);
    waw_hit = alu_wr && wb_en && (wb_rd == alu_rd);
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (ent_rd[i] == q_rs))  hit_a = 1'b1;
      if (ent_valid[i] && (ent_rd[i] == q_rs2)) hit_b = 1'b1;
      if (alu_wr && ent_valid[i] && (ent_rd[i] == alu_rd)) waw_hit = 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue: reset, latency, full/backpressure, push+pop wrap,
// WAW priority and mid-drain reset.
module tb_wb_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_rd;
  logic [DW-1:0] in_data;
  logic          alu_wr;
  logic [AW-1:0] alu_rd;
  logic [DW-1:0] alu_data;
  logic          wb_en;
  logic [AW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic [AW-1:0] q_rs;
  logic [AW-1:0] q_rs2;
  logic          hit_a;
  logic          hit_b;
  logic          waw_hit;
  logic [2:0]    count;
  logic          empty;
  logic          full;

  int n_vec = 0;
  int n_err = 0;
  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] exp_ent;

  wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_data(in_data),
    .alu_wr(alu_wr), .alu_rd(alu_rd), .alu_data(alu_data),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .q_rs(q_rs), .q_rs2(q_rs2), .hit_a(hit_a), .hit_b(hit_b), .waw_hit(waw_hit),
    .count(count), .empty(empty), .full(full)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  // drivers: inputs change 1 ns after the rising edge, checks happen there too
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_in(input logic [AW-1:0] rd, input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_rd    = rd;
    in_data  = d;
  endtask

  task automatic alu(input logic en, input logic [AW-1:0] rd, input logic [DW-1:0] d);
    alu_wr   = en;
    alu_rd   = rd;
    alu_data = d;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_rd = '0; in_data = '0;
    alu_wr = 1'b0; alu_rd = '0; alu_data = '0; q_rs = 5'd3; q_rs2 = 5'd5;
    step(); step();
    reset = 1'b0;
    repeat (5) step();
    chk("rst_wb_en", wb_en, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_hit_a", hit_a, 0);
    chk("rst_hit_b", hit_b, 0);
    chk("rst_wb_rd", wb_rd, 0);

    // single enqueue latency
    push_in(5'd3, 32'hDEADBEEF);
    step();
    in_valid = 1'b0;
    chk("lat_count1", count, 1);
    chk("lat_wb_en0", wb_en, 0);
    chk("lat_hit_c1", hit_a, 1);
    chk("lat_hit_b_c1", hit_b, 0);
    step();
    chk("lat_wb_en1", wb_en, 1);
    chk("lat_wb_rd", wb_rd, 3);
    chk("lat_wb_data", wb_data, 32'hDEADBEEF);
    chk("lat_count0", count, 0);
    chk("lat_hit_c2", hit_a, 1);
    step();
    chk("lat_wb_en2", wb_en, 0);
    chk("lat_hit_c3", hit_a, 0);

    // fill with ALU holding the port
    for (int i = 0; i < 4; i++) begin
      push_in(AW'(i + 1), 32'h11 * (i + 1));
      alu(1'b1, AW'(20 + i), 32'hC000_0000 + i);
      step();
      chk("fill_alu_en", wb_en, 1);
      chk("fill_alu_rd", wb_rd, 20 + i);
      chk("fill_alu_data", wb_data, 32'hC000_0000 + i);
    end
    chk("fill_full", full, 1);
    chk("fill_in_ready", in_ready, 0);
    chk("fill_count", count, 4);
    push_in(5'd9, 32'h99);
    alu(1'b1, 5'd24, 32'hC000_0004);
    step();
    chk("fifth_count", count, 4);
    chk("fifth_alu_rd", wb_rd, 24);
    in_valid = 1'b0;
    alu(1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("drain_en", wb_en, 1);
      chk("drain_rd", wb_rd, i + 1);
      chk("drain_data", wb_data, 32'h11 * (i + 1));
    end
    chk("drain_empty", empty, 1);
    step();
    chk("drain_idle", wb_en, 0);

    // prefill two entries under ALU, then 10 push+pop cycles to wrap pointers
    for (int k = 0; k < 2; k++) begin
      push_in(AW'(10 + k), 32'hA000_0000 + k);
      exp_q.push_back({AW'(10 + k), 32'hA000_0000 + k});
      alu(1'b1, 5'd30, 32'h3030);
      step();
    end
    alu(1'b0, 5'd0, 32'h0);
    chk("pp_count_pre", count, 2);
    for (int k = 2; k < 12; k++) begin
      push_in(AW'(10 + k), 32'hA000_0000 + k);
      exp_q.push_back({AW'(10 + k), 32'hA000_0000 + k});
      step();
      exp_ent = exp_q.pop_front();
      chk("pp_count", count, 2);
      chk("pp_en", wb_en, 1);
      chk("pp_entry", {wb_rd, wb_data}, exp_ent);
    end
    in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      exp_ent = exp_q.pop_front();
      chk("pp_tail_en", wb_en, 1);
      chk("pp_tail_entry", {wb_rd, wb_data}, exp_ent);
    end
    step();
    chk("pp_empty", empty, 1);
    chk("pp_idle", wb_en, 0);
    chk("pp_q_drained", exp_q.size(), 0);

    // WAW against a queued rd=7
    q_rs2 = 5'd7;
    push_in(5'd7, 32'h77);
    alu(1'b1, 5'd2, 32'h22);
    #1;
    chk("waw_none", waw_hit, 0);
    step();
    in_valid = 1'b0;
    chk("waw_hit_b", hit_b, 1);
    alu(1'b1, 5'd7, 32'hA7);
    #1;
    chk("waw_hit7", waw_hit, 1);
    step();
    chk("waw_alu_first_rd", wb_rd, 7);
    chk("waw_alu_first_data", wb_data, 32'hA7);
    chk("waw_count", count, 1);
    alu(1'b1, 5'd8, 32'hA8);
    #1;
    chk("waw_miss8", waw_hit, 0);
    step();
    chk("waw_alu8", wb_rd, 8);
    alu(1'b0, 5'd0, 32'h0);
    #1;
    chk("waw_gated", waw_hit, 0);
    step();
    chk("waw_q_rd", wb_rd, 7);
    chk("waw_q_data", wb_data, 32'h77);
    step();
    chk("waw_idle", wb_en, 0);

    // reset mid-queue discards entries
    for (int i = 0; i < 3; i++) begin
      push_in(AW'(20 + i), 32'hBAD0 + i);
      alu(1'b1, 5'd1, 32'h1);
      step();
    end
    in_valid = 1'b0;
    alu(1'b0, 5'd0, 32'h0);
    chk("mid_count3", count, 3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_count0", count, 0);
    chk("mid_wb_en", wb_en, 0);
    chk("mid_empty", empty, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mid_no_stale", wb_en, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/wb_queue.md
Name: wb_queue

Overview:
- Write-side companion to the 32x32 register file: buffers (rd, data) results from multi-cycle producers (load unit, multiplier) and sequences them onto the file's single write port (rd / busW / reg_wr).
- The ALU writeback has priority on the port. The queue drains one entry per free cycle.
- Exports pending-write hit flags so decode can stall on RAW/WAW hazards against queued or in-flight writes.

Parameters:
- DEPTH, 4, queue entries; power of two, >=2
- AW, 5, register address width
- DW, 32, data width

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high; clears all state
- in_valid  input  1  producer has a result to enqueue
- in_ready  output  1  queue can accept this cycle
- in_rd  input  AW  destination register of producer result
- in_data  input  DW  producer result
- alu_wr  input  1  ALU claims the write port this cycle
- alu_rd  input  AW  ALU destination register
- alu_data  input  DW  ALU result
- wb_en  output  1  register file reg_wr
- wb_rd  output  AW  register file write address
- wb_data  output  DW  register file busW
- q_rs  input  AW  hazard query A (decode rs)
- q_rs2  input  AW  hazard query B (decode rs2)
- hit_a  output  1  write to q_rs pending
- hit_b  output  1  write to q_rs2 pending
- waw_hit  output  1  alu_wr and alu_rd matches a pending queued or in-flight write
- count  output  $clog2(DEPTH+1)  stored entries
- empty  output  1  count==0
- full  output  1  count==DEPTH

Behaviour:
- Reset (synchronous, has priority over all other activity): rd/wr pointers=0, count=0, wb_en=0, wb_rd=0, wb_data=0, all entry valids cleared. Reset mid-drain discards queued entries; no wb_en pulse occurs in the cycle after reset.
- Enqueue
  - in_ready = !full, combinational from count only; no pass-through when full.
  - Accept on in_valid && in_ready: store {in_rd, in_data} at wr_ptr, then wr_ptr+1 mod DEPTH.
  - in_valid while full: ignored; the producer must hold.
- Write-port stage: registered, evaluated each edge.
  - If alu_wr: wb_en<=1, wb_rd<=alu_rd, wb_data<=alu_data; no pop.
  - Else if !empty: wb_en<=1, wb_rd/wb_data<=head entry; pop, rd_ptr+1 mod DEPTH.
  - Else: wb_en<=0; wb_rd/wb_data hold their values.
- Latency
  - Enqueue to wb_en: minimum 2 edges (accept edge, then pop edge). An entry is never popped in its enqueue cycle.
  - ALU to wb_en: 1 edge.
- Simultaneous push and pop: count unchanged, both pointers advance. Push with no pop: count+1. Pop with no push: count-1.
- Ordering: strict FIFO. Repeated writes to the same rd drain in arrival order, so the last value wins.
- Hazard flags (combinational): hit_a = any valid stored entry with rd==q_rs, OR (wb_en && wb_rd==q_rs). hit_b is the same for q_rs2. An in-flight wb stage counts because the register file has not yet captured it. The current-cycle in_* is not included.
- waw_hit: same match against alu_rd, gated by alu_wr. This is advisory; the block still gives the ALU priority. Upstream stalls the ALU when waw_hit=1.
- Register 0 has no special treatment; it is writable like any other.
- Starvation: continuous alu_wr blocks draining indefinitely; upstream must guarantee idle cycles.
- Pointer wrap: width $clog2(DEPTH). Full/empty are derived from count, never from pointer equality.

Test Plan:
- Reset then idle 5 cycles -> wb_en=0, count=0, empty=1, in_ready=1, hit_a=hit_b=0.
- Enqueue {rd=3, 0xDEADBEEF} at cycle 0, alu_wr=0 -> count=1 after edge 0; wb_en=1, wb_rd=3, wb_data=0xDEADBEEF after edge 1; count=0. q_rs=3 gives hit_a=1 during cycles 1 and 2, 0 in cycle 3.
- Fill 4 entries (rd 1..4, data 0x11..0x44) with alu_wr=1 held -> full=1, in_ready=0. A 5th in_valid is not accepted. wb_en shows ALU writes only. Drop alu_wr -> 4 consecutive wb_en pulses with rd 1,2,3,4 in order; then empty=1.
- Push and pop the same cycle at count=2 -> count stays 2. Run 10 such cycles to force pointer wrap; all data drains in order, no loss or duplication.
- Queue holds rd=7; assert alu_wr with alu_rd=7 -> waw_hit=1 and ALU data is written first. With alu_rd=8 -> waw_hit=0.
- Queue holds 3 entries, assert reset for 1 cycle -> count=0, wb_en=0 on the next cycle, no stale entry ever appears on wb_*.
